// File: rtl/fifo_rd_stream_pkg.sv
// ============================================================================
//  Module   : fifo_rd_stream_pkg
//  Brief    : Shared helpers for the FIFO read-side stream drainer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_stream_pkg;

    localparam int MAX_READ_LAT = 2;

    function automatic int calc_buf_aw(input int depth);
        return $clog2(depth);
    endfunction

    // Output buffer must hold every in-flight beat plus one draining beat.
    function automatic bit params_legal(input int read_lat, input int buf_depth);
        return (read_lat >= 0) && (read_lat <= MAX_READ_LAT) &&
               (buf_depth >= read_lat + 2) &&
               ((buf_depth & (buf_depth - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_stream_obuf.sv
// ============================================================================
//  Module   : stream_obuf
//  Brief    : Circular output buffer with write port and valid/ready read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_obuf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_rd;

    assign rd_valid = (r_level != '0);
    assign rd_data  = r_mem[r_rptr];
    assign level    = r_level;
    assign w_rd     = rd_valid & rd_ready;

    // Clear drops pointers and level only; stale storage is masked by rd_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (wr_en) begin
                r_mem[r_wptr] <= wr_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({wr_en, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
//  Module   : fifo_rd_stream
//  Brief    : Pops a synchronous FIFO and streams the data out as valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int READ_LAT  = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rinc,
    input  logic                       rempty,
    input  logic [WIDTH-1:0]           rdata,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(BUF_DEPTH):0] buf_lvl
);

    localparam int BUF_AW = calc_buf_aw(BUF_DEPTH);
    localparam int SUM_W  = BUF_AW + 2;

    generate
        if (!params_legal(READ_LAT, BUF_DEPTH)) begin : g_param_check
            $error("fifo_rd_stream: illegal READ_LAT/BUF_DEPTH combination");
        end
    endgenerate

    logic             w_pop;
    logic             w_arrive;
    logic [1:0]       w_inflight;
    logic [SUM_W-1:0] w_credit_used;

    generate
        if (READ_LAT == 0) begin : g_lat0
            assign w_arrive   = w_pop;
            assign w_inflight = 2'd0;
        end else begin : g_latn
            logic [READ_LAT-1:0] r_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pipe <= '0;
                end else if (flush) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= (r_pipe << 1) | READ_LAT'(w_pop);
                end
            end

            assign w_arrive   = r_pipe[READ_LAT-1];
            assign w_inflight = 2'($countones(r_pipe));
        end
    endgenerate

    // Credits count in-flight pops so an arriving beat always finds a free slot.
    assign w_credit_used = SUM_W'(buf_lvl) + SUM_W'(w_inflight);
    assign rinc          = ~rst & ~flush & (w_credit_used < SUM_W'(BUF_DEPTH));
    assign w_pop         = rinc & ~rempty;

    stream_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH),
        .AW    (BUF_AW)
    ) u_obuf (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .wr_en    (w_arrive),
        .wr_data  (rdata),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .level    (buf_lvl)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
//  Module   : tb_fifo_rd_stream
//  Brief    : Self-checking bench with a queue-based FIFO and stream model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

    localparam int WIDTH     = 8;
    localparam int READ_LAT  = 1;
    localparam int BUF_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             rinc;
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             flush;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       buf_lvl;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH     (WIDTH),
        .READ_LAT  (READ_LAT),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rinc    (rinc),
        .rempty  (rempty),
        .rdata   (rdata),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .buf_lvl (buf_lvl)
    );

    typedef struct {
        logic [7:0] d;
        int         due;
    } infl_t;

    typedef struct {
        logic       ready;
        logic       exp_rinc;
        logic       exp_valid;
        int         exp_lvl;
        logic [7:0] exp_data;
    } vec_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] mbuf[$];
    infl_t      infl[$];
    logic [7:0] got[$];
    vec_t       tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        rempty = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Checks DUT against the model, then applies one clock edge to model and FIFO.
    task automatic advance();
        logic  exp_rinc;
        logic  exp_valid;
        logic  pop;
        infl_t t;
        exp_rinc  = !flush && ((mbuf.size() + infl.size()) < BUF_DEPTH);
        exp_valid = (mbuf.size() != 0);
        chk("rinc", rinc, exp_rinc);
        chk("m_valid", m_valid, exp_valid);
        chk("buf_lvl", buf_lvl, mbuf.size());
        if (exp_valid) chk("m_data", m_data, mbuf[0]);
        if (m_valid && m_ready) got.push_back(m_data);
        pop = rinc && !rempty;

        if (exp_valid && m_ready) void'(mbuf.pop_front());
        if (flush) begin
            mbuf.delete();
            infl.delete();
        end else begin
            if (exp_rinc && fifo_q.size() != 0) infl.push_back('{fifo_q[0], cyc + READ_LAT});
            while (infl.size() != 0 && infl[0].due <= cyc) begin
                t = infl.pop_front();
                mbuf.push_back(t.d);
            end
        end
        cyc++;

        @(posedge clk);
        #1;
        if (pop && fifo_q.size() != 0) rdata = fifo_q.pop_front();
        else rdata = 8'($urandom);
        rempty = (fifo_q.size() == 0);
        flush  = 1'b0;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic do_reset(input logic [7:0] base, input int n);
        rst   = 1'b1;
        flush = 1'b0;
        fifo_q.delete();
        mbuf.delete();
        infl.delete();
        got.delete();
        rempty = 1'b1;
        for (int i = 0; i < n; i++) push(base + 8'(i));
        #1;
        chk("rst_rinc", rinc, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_buf_lvl", buf_lvl, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1, 8'h10};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 2, 8'h10};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3, 8'h10};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 4, 8'h10};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4, 8'h10};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4, 8'h10};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 3, 8'h11};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2, 8'h12};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 2, 8'h13};

        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = '0;

        // Reset with a non-empty FIFO, then back-pressured fill and release.
        do_reset(8'h10, 16);
        for (int i = 0; i < 11; i++) begin
            m_ready = tbl[i].ready;
            settle();
            chk($sformatf("tbl%0d_rinc", i), rinc, tbl[i].exp_rinc);
            chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_lvl", i), buf_lvl, tbl[i].exp_lvl);
            chk($sformatf("tbl%0d_data", i), m_data, tbl[i].exp_data);
            advance();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("t3_beats", got.size(), 16);
        for (int i = 0; i < got.size(); i++) chk($sformatf("t3_order%0d", i), got[i], 8'h10 + 8'(i));

        // Streaming latency and throughput with consumer always ready.
        do_reset(8'h10, 16);
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            settle();
            chk($sformatf("t2_valid_c%0d", c), m_valid, (c >= 2 && c <= 17));
            if (c >= 2 && c <= 17) chk($sformatf("t2_data_c%0d", c), m_data, 8'h10 + 8'(c - 2));
            if (c == 19) begin
                chk("t2_rempty", rempty, 1);
                chk("t2_rinc_when_empty", rinc, 1);
            end
            advance();
        end

        // Empty FIFO: rinc high but nothing transfers.
        do_reset(8'h00, 0);
        for (int i = 0; i < 10; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        settle();
        chk("t4_rinc", rinc, 1);
        chk("t4_valid", m_valid, 0);
        chk("t4_lvl", buf_lvl, 0);
        advance();

        // Flush with two beats buffered and one in flight.
        do_reset(8'h20, 16);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        flush = 1'b1;
        settle();
        chk("t5_lvl_before", buf_lvl, 2);
        chk("t5_rinc_flush", rinc, 0);
        advance();
        got.delete();
        settle();
        chk("t5_valid_after", m_valid, 0);
        chk("t5_lvl_after", buf_lvl, 0);
        advance();
        m_ready = 1'b1;
        for (int i = 0; i < 10 && got.size() == 0; i++) step();
        chk("t5_beat_seen", (got.size() != 0), 1);
        chk("t5_first_beat", (got.size() != 0) ? got[0] : 8'hFF, 8'h23);

        // Asynchronous reset mid-stream.
        do_reset(8'h30, 16);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        settle();
        chk("t6_lvl_before", buf_lvl, 3);
        do_reset(8'h40, 16);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("t6_first_beat", (got.size() != 0) ? got[0] : 8'hFF, 8'h40);

        // Random traffic, back-pressure and flushes against the model.
        for (int i = 0; i < 300; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 1) == 1 && fifo_q.size() < 20) push(8'($urandom));
            step();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 60; i++) step();
        settle();
        chk("drain_valid", m_valid, 0);
        chk("drain_lvl", buf_lvl, 0);
        chk("drain_rinc", rinc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
